// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multi-cycle shifter: shift modes and FSM state encoding.
// Package shift_pkg is imported by seq_shifter, shift_step and the bench.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle for seq_shifter; master drives requests, slave is the shifter.
interface seq_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_amt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_step.sv
// Single-step combinational shifter: shifts data by s bits in the given mode.
// Reusable as a full single-cycle shifter when driven with s up to WIDTH-1.
module shift_step
  import shift_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] s,
  input  shift_mode_e        mode,
  output logic [WIDTH-1:0]   result
);

  // Left-shift distance for the wrap-around half of a rotate; equals WIDTH when s==0,
  // which shifts everything out and leaves the rotate result equal to data.
  logic [SHAMT_W:0] wrap_amt;
  assign wrap_amt = (SHAMT_W+1)'(WIDTH) - {1'b0, s};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = data;
    case (mode)
      SH_SLL:  result = data << s;
      SH_SRL:  result = data >> s;
      SH_SRA:  result = $signed(data) >>> s;
      SH_ROTR: result = (data >> s) | (data << wrap_amt);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTR) moving at most STEP bits per clock, valid/ready on both sides.
// Optional macro SEQ_SHIFTER_FLUSH_EN adds a flush input that aborts an operation in SHIFT or DONE.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SEQ_SHIFTER_FLUSH_EN
  input  logic flush,
`endif
  seq_shifter_if.slave bus,
  output logic busy
);

  localparam int SHAMT_W = $clog2(WIDTH);
  // rem never exceeds WIDTH-1, so a STEP of WIDTH is capped to the largest encodable amount.
  localparam int unsigned STEP_CAP = (STEP >= WIDTH) ? WIDTH - 1 : STEP;
  localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(STEP_CAP);

  shift_state_e       state;
  shift_mode_e        mode_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] rem_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [SHAMT_W-1:0] step_s;
  logic [WIDTH-1:0]   step_data;

  assign step_s = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (data_q),
    .s      (step_s),
    .mode   (mode_q),
    .result (step_data)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign busy          = busy_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_q      <= SH_SLL;
      data_q      <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            mode_q     <= shift_mode_e'(bus.in_mode);
            rem_q      <= bus.in_amt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.in_amt == '0) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_q <= step_data;
          rem_q  <= rem_q - step_s;
          if (rem_q == step_s) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
`ifdef SEQ_SHIFTER_FLUSH_EN
      // Later assignments override the case above; the data register keeps its pre-edge value.
      if (flush && state != ST_IDLE) begin
        state       <= ST_IDLE;
        data_q      <= data_q;
        rem_q       <= '0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
        busy_q      <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: 32-bit/STEP=4 instance plus 8-bit instances with STEP=1 and STEP=8.
// Flush scenario runs only when SEQ_SHIFTER_FLUSH_EN is defined.
module tb_seq_shifter;
  import shift_pkg::*;

  localparam int LAT_LIMIT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_shifter_if #(.WIDTH(32)) b32 ();
  seq_shifter_if #(.WIDTH(8))  b8a ();
  seq_shifter_if #(.WIDTH(8))  b8b ();
  logic busy32, busy8a, busy8b;
`ifdef SEQ_SHIFTER_FLUSH_EN
  logic flush32 = 1'b0;
`endif

  seq_shifter #(.WIDTH(32), .STEP(4)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SEQ_SHIFTER_FLUSH_EN
    .flush (flush32),
`endif
    .bus   (b32),
    .busy  (busy32)
  );

  seq_shifter #(.WIDTH(8), .STEP(1)) u8a (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SEQ_SHIFTER_FLUSH_EN
    .flush (1'b0),
`endif
    .bus   (b8a),
    .busy  (busy8a)
  );

  seq_shifter #(.WIDTH(8), .STEP(8)) u8b (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SEQ_SHIFTER_FLUSH_EN
    .flush (1'b0),
`endif
    .bus   (b8b),
    .busy  (busy8b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic run32(input logic [31:0] d, input logic [4:0] amt, input logic [1:0] mode,
                       input bit consume, output int lat, output logic [31:0] res);
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = d; b32.in_amt = amt; b32.in_mode = mode;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 1;
    while (b32.out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b32.out_data;
    if (consume) begin
      @(negedge clk); b32.out_ready = 1'b1;
      @(posedge clk); #1; b32.out_ready = 1'b0;
    end
  endtask

  task automatic run8a(input logic [7:0] d, input logic [2:0] amt, input logic [1:0] mode,
                       output int lat, output logic [7:0] res);
    @(negedge clk);
    b8a.in_valid = 1'b1; b8a.in_data = d; b8a.in_amt = amt; b8a.in_mode = mode;
    @(posedge clk); #1;
    b8a.in_valid = 1'b0;
    lat = 1;
    while (b8a.out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b8a.out_data;
    @(negedge clk); b8a.out_ready = 1'b1;
    @(posedge clk); #1; b8a.out_ready = 1'b0;
  endtask

  task automatic run8b(input logic [7:0] d, input logic [2:0] amt, input logic [1:0] mode,
                       output int lat, output logic [7:0] res);
    @(negedge clk);
    b8b.in_valid = 1'b1; b8b.in_data = d; b8b.in_amt = amt; b8b.in_mode = mode;
    @(posedge clk); #1;
    b8b.in_valid = 1'b0;
    lat = 1;
    while (b8b.out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b8b.out_data;
    @(negedge clk); b8b.out_ready = 1'b1;
    @(posedge clk); #1; b8b.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", b32.in_ready); end
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", b32.out_valid); end
    n_cmp++; if (b32.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 00000000", b32.out_data); end
    n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy32); end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [31:0] res;
    run32(32'h0000_0001, 5'd5, SH_SLL, 1'b1, lat, res);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL sll5_latency: got %0d want 3", lat); end
    n_cmp++; if (res !== 32'h0000_0020) begin n_err++; $display("FAIL sll5_data: got %h want 00000020", res); end
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = 32'h0000_0001; b32.in_amt = 5'd20; b32.in_mode = SH_SLL;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    n_cmp++; if (busy32 !== 1'b1) begin n_err++; $display("FAIL midop_busy: got %b want 1", busy32); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", b32.in_ready); end
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", b32.out_valid); end
    n_cmp++; if (b32.out_data !== 32'h0) begin n_err++; $display("FAIL midrst_out_data: got %h want 00000000", b32.out_data); end
    n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy32); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sra_srl();
    int lat;
    logic [31:0] res;
    run32(32'h8000_0000, 5'd31, SH_SRA, 1'b1, lat, res);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL sra31_latency: got %0d want 9", lat); end
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sra31_data: got %h want ffffffff", res); end
    run32(32'h8000_0000, 5'd31, SH_SRL, 1'b1, lat, res);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL srl31_latency: got %0d want 9", lat); end
    n_cmp++; if (res !== 32'h0000_0001) begin n_err++; $display("FAIL srl31_data: got %h want 00000001", res); end
  endtask

  task automatic test_rotr();
    int lat;
    logic [31:0] res;
    run32(32'h1234_5678, 5'd8, SH_ROTR, 1'b1, lat, res);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rotr8_latency: got %0d want 3", lat); end
    n_cmp++; if (res !== 32'h7812_3456) begin n_err++; $display("FAIL rotr8_data: got %h want 78123456", res); end
    run32(32'h1234_5678, 5'd0, SH_ROTR, 1'b1, lat, res);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rotr0_latency: got %0d want 1", lat); end
    n_cmp++; if (res !== 32'h1234_5678) begin n_err++; $display("FAIL rotr0_data: got %h want 12345678", res); end
  endtask

  task automatic test_mode_hold();
    int lat;
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = 32'hF000_0000; b32.in_amt = 5'd8; b32.in_mode = SH_SRL;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    b32.in_mode  = SH_SLL;
    lat = 1;
    while (b32.out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL modehold_latency: got %0d want 3", lat); end
    n_cmp++; if (b32.out_data !== 32'h00F0_0000) begin n_err++; $display("FAIL modehold_data: got %h want 00f00000", b32.out_data); end
    @(negedge clk); b32.out_ready = 1'b1;
    @(posedge clk); #1; b32.out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    int lat;
    logic [31:0] res;
    run32(32'h0000_0003, 5'd4, SH_SLL, 1'b0, lat, res);
    n_cmp++; if (res !== 32'h0000_0030) begin n_err++; $display("FAIL bp_data: got %h want 00000030", res); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b32.in_valid = 1'b1; b32.in_data = 32'hDEAD_BEEF; b32.in_amt = 5'd3; b32.in_mode = SH_SRL;
      @(posedge clk); #1;
      n_cmp++; if (b32.out_data !== 32'h0000_0030) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want 00000030", i, b32.out_data); end
      n_cmp++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, b32.in_ready); end
      n_cmp++; if (b32.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, b32.out_valid); end
    end
    @(negedge clk);
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", b32.in_ready); end
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid: got %b want 0", b32.out_valid); end
    run32(32'h0000_0100, 5'd4, SH_SRL, 1'b1, lat, res);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL bp_next_latency: got %0d want 2", lat); end
    n_cmp++; if (res !== 32'h0000_0010) begin n_err++; $display("FAIL bp_next_data: got %h want 00000010", res); end
  endtask

  task automatic test_step_sweep();
    int lat;
    logic [7:0] res;
    run8a(8'h81, 3'd7, SH_SLL, lat, res);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL step1_latency: got %0d want 8", lat); end
    n_cmp++; if (res !== 8'h80) begin n_err++; $display("FAIL step1_data: got %h want 80", res); end
    run8b(8'h81, 3'd7, SH_SLL, lat, res);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL step8_latency: got %0d want 2", lat); end
    n_cmp++; if (res !== 8'h80) begin n_err++; $display("FAIL step8_data: got %h want 80", res); end
    run8a(8'h81, 3'd1, SH_ROTR, lat, res);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL step1_rotr_latency: got %0d want 2", lat); end
    n_cmp++; if (res !== 8'hC0) begin n_err++; $display("FAIL step1_rotr_data: got %h want c0", res); end
    run8b(8'h80, 3'd7, SH_SRA, lat, res);
    n_cmp++; if (res !== 8'hFF) begin n_err++; $display("FAIL step8_sra_data: got %h want ff", res); end
  endtask

`ifdef SEQ_SHIFTER_FLUSH_EN
  task automatic test_flush();
    int lat;
    logic [31:0] res;
    bit saw_valid;
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = 32'h0000_0001; b32.in_amt = 5'd20; b32.in_mode = SH_SLL;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    @(negedge clk); flush32 = 1'b1;
    @(posedge clk); #1; flush32 = 1'b0;
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", b32.in_ready); end
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", b32.out_valid); end
    n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy32); end
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b32.out_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_cmp++; if (saw_valid) begin n_err++; $display("FAIL flush_no_pulse: got pulse want none"); end
    run32(32'h0000_000A, 5'd4, SH_SLL, 1'b1, lat, res);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL flush_next_latency: got %0d want 2", lat); end
    n_cmp++; if (res !== 32'h0000_00A0) begin n_err++; $display("FAIL flush_next_data: got %h want 000000a0", res); end
  endtask
`endif

  initial begin
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_amt = '0; b32.in_mode = '0; b32.out_ready = 1'b0;
    b8a.in_valid = 1'b0; b8a.in_data = '0; b8a.in_amt = '0; b8a.in_mode = '0; b8a.out_ready = 1'b0;
    b8b.in_valid = 1'b0; b8b.in_data = '0; b8b.in_amt = '0; b8b.in_mode = '0; b8b.out_ready = 1'b0;
    rst_n = 1'b0;
    #23;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_reset_mid_op();
    test_sra_srl();
    test_rotr();
    test_mode_hold();
    test_back_pressure();
    test_step_sweep();
`ifdef SEQ_SHIFTER_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
